// File: rtl/riscv_dmem_responder.sv
// Data-memory responder: val/rdy requests onto a byte-addressable word array, in-order responses after LATENCY cycles.
// Defining RISCV_DMEM_BOUNDS_CHECK_EN adds a sticky oob_err output and suppresses out-of-range accesses.
module riscv_dmem_responder #(
    parameter int ADDR_BITS = 18,
    parameter int LATENCY   = 1,
    parameter int DEPTH     = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        memreq_val,
    output logic        memreq_rdy,
    input  logic        memreq_msg_type,
    input  logic [31:0] memreq_msg_addr,
    input  logic [1:0]  memreq_msg_len,
    input  logic [31:0] memreq_msg_data,
    output logic        memresp_val,
    input  logic        memresp_rdy,
    output logic        memresp_msg_type,
    output logic [31:0] memresp_msg_data
`ifdef RISCV_DMEM_BOUNDS_CHECK_EN
    ,
    output logic        oob_err
`endif
);

    localparam int WORDS = 1 << ADDR_BITS;
    localparam int PW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW    = $clog2(DEPTH + 1);
    localparam int OW    = ((CW > 4) ? CW : 4) + 1;

    typedef enum logic [1:0] {
        LEN_WORD = 2'd0,
        LEN_BYTE = 2'd1,
        LEN_HALF = 2'd2,
        LEN_RSVD = 2'd3
    } len_e;

    typedef struct packed {
        logic        val;
        logic        typ;
        logic [31:0] data;
    } entry_t;

    // NOTE: the array and FIFO payload are deliberately left out of reset; only control state is cleared.
    logic [31:0] mem [WORDS];

    logic                 accept;
    logic                 oob;
    logic [ADDR_BITS-1:0] index;
    len_e                 len;
    logic [3:0]           lane_en;
    logic [31:0]          wdata;
    logic [31:0]          rword;
    logic [31:0]          rdata;
    entry_t               in_e;
    entry_t               out_e;

    logic [3:0]           inflight;
    logic [CW-1:0]        count;
    logic [PW-1:0]        wr_ptr;
    logic [PW-1:0]        rd_ptr;
    logic [OW-1:0]        outstanding;
    logic                 enq;
    logic                 deq;
    logic [31:0]          fifo_data [DEPTH];
    logic                 fifo_type [DEPTH];

    assign accept = memreq_val && memreq_rdy;
    assign index  = memreq_msg_addr[ADDR_BITS+1:2];
    assign len    = len_e'(memreq_msg_len);
    assign rword  = mem[index];

`ifdef RISCV_DMEM_BOUNDS_CHECK_EN
    assign oob = |memreq_msg_addr[31:ADDR_BITS+2];
`else
    logic unused_addr_bits;
    assign oob              = 1'b0;
    assign unused_addr_bits = &{1'b0, memreq_msg_addr[31:ADDR_BITS+2]};
`endif

    // NOTE: every combinational output is given a default first so no path can infer a latch.
    always_comb begin
        lane_en = 4'b1111;
        wdata   = memreq_msg_data;
        rdata   = rword;
        case (len)
            LEN_BYTE: begin
                lane_en = 4'b0001 << memreq_msg_addr[1:0];
                wdata   = {4{memreq_msg_data[7:0]}};
                rdata   = {24'b0, rword[{memreq_msg_addr[1:0], 3'b000} +: 8]};
            end
            LEN_HALF: begin
                lane_en = memreq_msg_addr[1] ? 4'b1100 : 4'b0011;
                wdata   = {2{memreq_msg_data[15:0]}};
                rdata   = memreq_msg_addr[1] ? {16'b0, rword[31:16]} : {16'b0, rword[15:0]};
            end
            default: ;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (accept && memreq_msg_type && !oob) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) mem[index][8*b +: 8] <= wdata[8*b +: 8];
            end
        end
    end

    always_comb begin
        in_e.val  = accept;
        in_e.typ  = memreq_msg_type;
        in_e.data = (memreq_msg_type || oob) ? 32'b0 : rdata;
    end

    // The FIFO write is the last latency stage, so only LATENCY-1 pipeline registers sit in front of it.
    generate
        if (LATENCY > 1) begin : g_pipe
            entry_t stage [LATENCY-1];
            always_ff @(posedge clk) begin
                if (reset) begin
                    for (int i = 0; i < LATENCY - 1; i++) stage[i].val <= 1'b0;
                end else begin
                    stage[0] <= in_e;
                    for (int i = 1; i < LATENCY - 1; i++) stage[i] <= stage[i-1];
                end
            end
            assign out_e = stage[LATENCY-2];
        end else begin : g_direct
            assign out_e = in_e;
        end
    endgenerate

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign enq = out_e.val;
    assign deq = memresp_val && memresp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            inflight <= 4'd0;
            count    <= '0;
            wr_ptr   <= '0;
            rd_ptr   <= '0;
        end else begin
            inflight <= (LATENCY > 1) ? inflight + {3'b0, accept} - {3'b0, out_e.val} : 4'd0;
            count    <= count + CW'(enq) - CW'(deq);
            if (enq) wr_ptr <= ptr_inc(wr_ptr);
            if (deq) rd_ptr <= ptr_inc(rd_ptr);
        end
    end

    always_ff @(posedge clk) begin
        if (enq) begin
            fifo_data[wr_ptr] <= out_e.data;
            fifo_type[wr_ptr] <= out_e.typ;
        end
    end

    // Ready looks only at registered occupancy; a same-cycle dequeue frees space one cycle later.
    assign outstanding      = OW'(inflight) + OW'(count);
    assign memreq_rdy       = !reset && (outstanding < OW'(DEPTH));
    assign memresp_val      = !reset && (count != '0);
    assign memresp_msg_type = memresp_val && fifo_type[rd_ptr];
    assign memresp_msg_data = memresp_val ? fifo_data[rd_ptr] : 32'b0;

`ifdef RISCV_DMEM_BOUNDS_CHECK_EN
    always_ff @(posedge clk) begin
        if (reset) oob_err <= 1'b0;
        else if (accept && oob) oob_err <= 1'b1;
    end
`endif

endmodule
